// File: rtl/smp_pkg.sv
// Shared types for the audio RAM arbiter: requester ids and the read-tag record.
package smp_pkg;

    localparam int ARAM_AW = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DSP  = 2'd1,
        OWN_SMP  = 2'd2,
        OWN_HOST = 2'd3
    } owner_t;

    // One entry of the read-return pipe: is it a read, and who gets the data.
    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;

endpackage

// File: rtl/aram_arbiter_if.sv
// Requester and memory-controller signals of the audio RAM arbiter.
// slave is the arbiter's view; master is the view of everything around it.
interface aram_arbiter_if;
    import smp_pkg::*;

    logic               DSP_REQ;
    logic [ARAM_AW-1:0] DSP_A;
    logic [7:0]         DSP_DO;
    logic               DSP_WE_N;
    logic               DSP_ACK;
    logic [7:0]         DSP_DI;
    logic               DSP_RVALID;

    logic               SMP_REQ;
    logic [ARAM_AW-1:0] SMP_A;
    logic [7:0]         SMP_DO;
    logic               SMP_WE_N;
    logic               SMP_ACK;
    logic [7:0]         SMP_DI;
    logic               SMP_RVALID;

    logic               HOST_REQ;
    logic [ARAM_AW-1:0] HOST_A;
    logic [7:0]         HOST_DO;
    logic               HOST_WE_N;
    logic               HOST_ACK;
    logic [7:0]         HOST_DI;
    logic               HOST_RVALID;
    logic               HOST_LOCK;

    logic               MEM_CE;
    logic [ARAM_AW-1:0] MEM_A;
    logic [7:0]         MEM_DO;
    logic               MEM_WE_N;
    logic [7:0]         MEM_DI;

    modport slave (
        input  DSP_REQ, DSP_A, DSP_DO, DSP_WE_N,
        output DSP_ACK, DSP_DI, DSP_RVALID,
        input  SMP_REQ, SMP_A, SMP_DO, SMP_WE_N,
        output SMP_ACK, SMP_DI, SMP_RVALID,
        input  HOST_REQ, HOST_A, HOST_DO, HOST_WE_N, HOST_LOCK,
        output HOST_ACK, HOST_DI, HOST_RVALID,
        output MEM_CE, MEM_A, MEM_DO, MEM_WE_N,
        input  MEM_DI
    );

    modport master (
        output DSP_REQ, DSP_A, DSP_DO, DSP_WE_N,
        input  DSP_ACK, DSP_DI, DSP_RVALID,
        output SMP_REQ, SMP_A, SMP_DO, SMP_WE_N,
        input  SMP_ACK, SMP_DI, SMP_RVALID,
        output HOST_REQ, HOST_A, HOST_DO, HOST_WE_N, HOST_LOCK,
        input  HOST_ACK, HOST_DI, HOST_RVALID,
        input  MEM_CE, MEM_A, MEM_DO, MEM_WE_N,
        output MEM_DI
    );

endinterface

// File: rtl/aram_tag_pipe.sv
// Fixed-depth shift register that carries the owner of each read alongside the
// memory latency, so returning data can be steered back to whoever asked for it.
module aram_tag_pipe
    import smp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  tag_t in_tag,
    output tag_t out_tag
);

    tag_t stage_q [DEPTH];

    // Shift one stage per clock; reset drops every read still in flight.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/aram_arbiter.sv
// Three-way arbiter for the single audio RAM port (DSP, SMP, HOST).
// Winner is picked combinationally from the live requests; the access itself is
// launched from registers one cycle later. Read tags enter the tag pipe on the
// same edge that raises MEM_CE, so the last stage lines up with MEM_DI and the
// owner's RVALID lands exactly MEM_LAT cycles after its ACK.
module aram_arbiter
    import smp_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 15
) (
    input  logic           CLK,
    input  logic           RST_N,
    aram_arbiter_if.slave  bus
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic               dsp_elig;
    logic               smp_elig;
    logic               host_elig;
    owner_t             winner;
    logic [ARAM_AW-1:0] win_a;
    logic [7:0]         win_do;
    logic               win_we_n;
    logic [SW-1:0]      starve_q;
    tag_t               issue_tag;
    tag_t               ret_tag;

    // Pick this cycle's winner; an ACKed requester sits out one cycle, and a
    // locked port or a starved HOST overrides the fixed DSP > SMP > HOST order.
    always_comb begin
        dsp_elig  = bus.DSP_REQ  && !bus.DSP_ACK && !bus.HOST_LOCK;
        smp_elig  = bus.SMP_REQ  && !bus.SMP_ACK && !bus.HOST_LOCK;
        host_elig = bus.HOST_REQ && !bus.HOST_ACK;
        winner    = OWN_NONE;
        if (bus.HOST_LOCK) begin
            if (host_elig) begin
                winner = OWN_HOST;
            end
        end else if (host_elig && (starve_q == STARVE_LIM)) begin
            winner = OWN_HOST;
        end else if (dsp_elig) begin
            winner = OWN_DSP;
        end else if (smp_elig) begin
            winner = OWN_SMP;
        end else if (host_elig) begin
            winner = OWN_HOST;
        end
    end

    // Route the winner's address, data and direction toward the MEM registers.
    always_comb begin
        win_a    = '0;
        win_do   = '0;
        win_we_n = 1'b1;
        case (winner)
            OWN_DSP: begin
                win_a    = bus.DSP_A;
                win_do   = bus.DSP_DO;
                win_we_n = bus.DSP_WE_N;
            end
            OWN_SMP: begin
                win_a    = bus.SMP_A;
                win_do   = bus.SMP_DO;
                win_we_n = bus.SMP_WE_N;
            end
            OWN_HOST: begin
                win_a    = bus.HOST_A;
                win_do   = bus.HOST_DO;
                win_we_n = bus.HOST_WE_N;
            end
            default: begin
                win_a    = '0;
                win_do   = '0;
                win_we_n = 1'b1;
            end
        endcase
        issue_tag.valid = (winner != OWN_NONE) && win_we_n;
        issue_tag.owner = winner;
    end

    // Count how long HOST has been waiting, saturating so it stays eligible for the override.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            starve_q <= '0;
        end else if (!bus.HOST_REQ || (winner == OWN_HOST)) begin
            starve_q <= '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_q <= starve_q + SW'(1);
        end
    end

    // Launch the winning access and pulse its ACK; address and data hold when idle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bus.DSP_ACK  <= 1'b0;
            bus.SMP_ACK  <= 1'b0;
            bus.HOST_ACK <= 1'b0;
            bus.MEM_CE   <= 1'b0;
            bus.MEM_WE_N <= 1'b1;
            bus.MEM_A    <= '0;
            bus.MEM_DO   <= '0;
        end else begin
            bus.DSP_ACK  <= (winner == OWN_DSP);
            bus.SMP_ACK  <= (winner == OWN_SMP);
            bus.HOST_ACK <= (winner == OWN_HOST);
            if (winner != OWN_NONE) begin
                bus.MEM_CE   <= 1'b1;
                bus.MEM_WE_N <= win_we_n;
                bus.MEM_A    <= win_a;
                bus.MEM_DO   <= win_do;
            end else begin
                bus.MEM_CE   <= 1'b0;
                bus.MEM_WE_N <= 1'b1;
            end
        end
    end

    aram_tag_pipe #(
        .DEPTH (MEM_LAT)
    ) u_tag_pipe (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .in_tag  (issue_tag),
        .out_tag (ret_tag)
    );

    // Capture returning read data for the tagged owner; other owners keep their last data.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bus.DSP_RVALID  <= 1'b0;
            bus.SMP_RVALID  <= 1'b0;
            bus.HOST_RVALID <= 1'b0;
            bus.DSP_DI      <= '0;
            bus.SMP_DI      <= '0;
            bus.HOST_DI     <= '0;
        end else begin
            bus.DSP_RVALID  <= ret_tag.valid && (ret_tag.owner == OWN_DSP);
            bus.SMP_RVALID  <= ret_tag.valid && (ret_tag.owner == OWN_SMP);
            bus.HOST_RVALID <= ret_tag.valid && (ret_tag.owner == OWN_HOST);
            if (ret_tag.valid && (ret_tag.owner == OWN_DSP)) begin
                bus.DSP_DI <= bus.MEM_DI;
            end
            if (ret_tag.valid && (ret_tag.owner == OWN_SMP)) begin
                bus.SMP_DI <= bus.MEM_DI;
            end
            if (ret_tag.valid && (ret_tag.owner == OWN_HOST)) begin
                bus.HOST_DI <= bus.MEM_DI;
            end
        end
    end

endmodule

// File: tb/tb_aram_arbiter.sv
// Directed bench for aram_arbiter with MEM_LAT=2, STARVE_MAX=15.
// The memory model is a synchronous RAM: MEM_DI shows the read data the cycle
// after MEM_CE; untouched locations read back as their low address byte.
module tb_aram_arbiter;

    logic CLK;
    logic RST_N;
    int   n_compared;
    int   n_mismatched;

    logic [7:0] mem      [65536];
    bit         mem_wr   [65536];

    aram_arbiter_if bus ();

    aram_arbiter #(
        .MEM_LAT    (2),
        .STARVE_MAX (15)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Synchronous RAM model sitting behind the MEM_* port.
    always @(posedge CLK) begin
        if (bus.MEM_CE) begin
            if (!bus.MEM_WE_N) begin
                mem[bus.MEM_A]    <= bus.MEM_DO;
                mem_wr[bus.MEM_A] <= 1'b1;
            end else begin
                bus.MEM_DI <= mem_wr[bus.MEM_A] ? mem[bus.MEM_A] : bus.MEM_A[7:0];
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) step();
        n_compared++;
        if ({bus.DSP_ACK, bus.SMP_ACK, bus.HOST_ACK, bus.DSP_RVALID, bus.SMP_RVALID, bus.HOST_RVALID} !== 6'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_ack_rvalid: got %b expected 000000",
                     {bus.DSP_ACK, bus.SMP_ACK, bus.HOST_ACK, bus.DSP_RVALID, bus.SMP_RVALID, bus.HOST_RVALID});
        end
        n_compared++;
        if ({bus.MEM_CE, bus.MEM_WE_N, bus.MEM_A, bus.MEM_DO} !== {1'b0, 1'b1, 16'h0000, 8'h00}) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mem: got ce=%b we_n=%b a=%h do=%h expected 0 1 0000 00",
                     bus.MEM_CE, bus.MEM_WE_N, bus.MEM_A, bus.MEM_DO);
        end
        n_compared++;
        if ({bus.DSP_DI, bus.SMP_DI, bus.HOST_DI} !== 24'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_di: got %h expected 000000", {bus.DSP_DI, bus.SMP_DI, bus.HOST_DI});
        end
        RST_N = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        bus.SMP_A    = 16'hFFC0;
        bus.SMP_WE_N = 1'b1;
        bus.SMP_REQ  = 1'b1;
        step();
        n_compared++;
        if ({bus.SMP_ACK, bus.MEM_CE, bus.MEM_WE_N, bus.MEM_A} !== {1'b1, 1'b1, 1'b1, 16'hFFC0}) begin
            n_mismatched++;
            $display("[TB] FAIL read_issue: got ack=%b ce=%b we_n=%b a=%h expected 1 1 1 ffc0",
                     bus.SMP_ACK, bus.MEM_CE, bus.MEM_WE_N, bus.MEM_A);
        end
        bus.SMP_REQ = 1'b0;
        step();
        n_compared++;
        if ({bus.SMP_ACK, bus.SMP_RVALID, bus.MEM_CE} !== 3'b000) begin
            n_mismatched++;
            $display("[TB] FAIL read_gap: got ack=%b rvalid=%b ce=%b expected 0 0 0",
                     bus.SMP_ACK, bus.SMP_RVALID, bus.MEM_CE);
        end
        step();
        n_compared++;
        if ({bus.SMP_RVALID, bus.SMP_DI, bus.DSP_RVALID, bus.HOST_RVALID} !== {1'b1, 8'hC0, 1'b0, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL read_return: got rvalid=%b di=%h dsp_rv=%b host_rv=%b expected 1 c0 0 0",
                     bus.SMP_RVALID, bus.SMP_DI, bus.DSP_RVALID, bus.HOST_RVALID);
        end
        step();
        n_compared++;
        if ({bus.SMP_RVALID, bus.SMP_DI} !== {1'b0, 8'hC0}) begin
            n_mismatched++;
            $display("[TB] FAIL read_hold: got rvalid=%b di=%h expected 0 c0", bus.SMP_RVALID, bus.SMP_DI);
        end
        repeat (2) step();
    endtask

    task automatic test_alternate();
        bus.DSP_A    = 16'h0100;
        bus.DSP_WE_N = 1'b1;
        bus.SMP_A    = 16'h0200;
        bus.SMP_WE_N = 1'b1;
        bus.DSP_REQ  = 1'b1;
        bus.SMP_REQ  = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            n_compared++;
            if ({bus.DSP_ACK, bus.SMP_ACK, bus.MEM_CE, bus.MEM_A} !==
                {(k % 2 == 1), (k % 2 == 0), 1'b1, (k % 2 == 1) ? 16'h0100 : 16'h0200}) begin
                n_mismatched++;
                $display("[TB] FAIL alternate_k%0d: got dsp=%b smp=%b ce=%b a=%h", k,
                         bus.DSP_ACK, bus.SMP_ACK, bus.MEM_CE, bus.MEM_A);
            end
        end
        bus.DSP_REQ = 1'b0;
        bus.SMP_REQ = 1'b0;
        step();
        n_compared++;
        if ({bus.MEM_CE, bus.MEM_WE_N, bus.MEM_A} !== {1'b0, 1'b1, 16'h0200}) begin
            n_mismatched++;
            $display("[TB] FAIL idle_hold: got ce=%b we_n=%b a=%h expected 0 1 0200",
                     bus.MEM_CE, bus.MEM_WE_N, bus.MEM_A);
        end
        repeat (3) step();
    endtask

    task automatic test_starve();
        bus.DSP_A     = 16'h0300;
        bus.SMP_A     = 16'h0400;
        bus.HOST_A    = 16'h0500;
        bus.DSP_WE_N  = 1'b1;
        bus.SMP_WE_N  = 1'b1;
        bus.HOST_WE_N = 1'b1;
        bus.DSP_REQ   = 1'b1;
        bus.SMP_REQ   = 1'b1;
        repeat (2) step();
        bus.HOST_REQ = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            n_compared++;
            if ({bus.HOST_ACK, bus.MEM_CE} !== {(k == 16 || k == 32), 1'b1}) begin
                n_mismatched++;
                $display("[TB] FAIL starve_k%0d: got host_ack=%b ce=%b expected %b 1", k,
                         bus.HOST_ACK, bus.MEM_CE, (k == 16 || k == 32));
            end
            if (k == 16) begin
                n_compared++;
                if ({bus.DSP_ACK, bus.SMP_ACK, bus.MEM_A} !== {1'b0, 1'b0, 16'h0500}) begin
                    n_mismatched++;
                    $display("[TB] FAIL starve_win: got dsp=%b smp=%b a=%h expected 0 0 0500",
                             bus.DSP_ACK, bus.SMP_ACK, bus.MEM_A);
                end
            end
        end
        bus.DSP_REQ  = 1'b0;
        bus.SMP_REQ  = 1'b0;
        bus.HOST_REQ = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_host_lock();
        bus.HOST_LOCK = 1'b1;
        bus.DSP_A     = 16'h0600;
        bus.SMP_A     = 16'h0700;
        bus.DSP_REQ   = 1'b1;
        bus.SMP_REQ   = 1'b1;
        bus.HOST_A    = 16'h0000;
        bus.HOST_DO   = 8'h5A;
        bus.HOST_WE_N = 1'b0;
        bus.HOST_REQ  = 1'b1;
        step();
        n_compared++;
        if ({bus.HOST_ACK, bus.DSP_ACK, bus.SMP_ACK, bus.MEM_CE, bus.MEM_WE_N, bus.MEM_A, bus.MEM_DO} !==
            {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h5A}) begin
            n_mismatched++;
            $display("[TB] FAIL lock_write: got h=%b d=%b s=%b ce=%b we_n=%b a=%h do=%h",
                     bus.HOST_ACK, bus.DSP_ACK, bus.SMP_ACK, bus.MEM_CE, bus.MEM_WE_N, bus.MEM_A, bus.MEM_DO);
        end
        bus.HOST_WE_N = 1'b1;
        step();
        n_compared++;
        if ({bus.HOST_ACK, bus.DSP_ACK, bus.SMP_ACK, bus.MEM_CE} !== 4'b0000) begin
            n_mismatched++;
            $display("[TB] FAIL lock_gap: got h=%b d=%b s=%b ce=%b expected 0 0 0 0",
                     bus.HOST_ACK, bus.DSP_ACK, bus.SMP_ACK, bus.MEM_CE);
        end
        step();
        n_compared++;
        if ({bus.HOST_ACK, bus.DSP_ACK, bus.SMP_ACK, bus.MEM_CE, bus.MEM_WE_N} !== 5'b10011) begin
            n_mismatched++;
            $display("[TB] FAIL lock_read: got h=%b d=%b s=%b ce=%b we_n=%b expected 1 0 0 1 1",
                     bus.HOST_ACK, bus.DSP_ACK, bus.SMP_ACK, bus.MEM_CE, bus.MEM_WE_N);
        end
        bus.HOST_REQ = 1'b0;
        step();
        n_compared++;
        if ({bus.DSP_ACK, bus.SMP_ACK, bus.HOST_RVALID} !== 3'b000) begin
            n_mismatched++;
            $display("[TB] FAIL lock_idle: got d=%b s=%b host_rv=%b expected 0 0 0",
                     bus.DSP_ACK, bus.SMP_ACK, bus.HOST_RVALID);
        end
        step();
        n_compared++;
        if ({bus.HOST_RVALID, bus.HOST_DI, bus.DSP_ACK, bus.SMP_ACK} !== {1'b1, 8'h5A, 1'b0, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL lock_return: got rv=%b di=%h d=%b s=%b expected 1 5a 0 0",
                     bus.HOST_RVALID, bus.HOST_DI, bus.DSP_ACK, bus.SMP_ACK);
        end
        bus.HOST_LOCK = 1'b0;
        step();
        n_compared++;
        if ({bus.DSP_ACK, bus.SMP_ACK, bus.MEM_A} !== {1'b1, 1'b0, 16'h0600}) begin
            n_mismatched++;
            $display("[TB] FAIL unlock: got d=%b s=%b a=%h expected 1 0 0600",
                     bus.DSP_ACK, bus.SMP_ACK, bus.MEM_A);
        end
        bus.DSP_REQ = 1'b0;
        bus.SMP_REQ = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_back_to_back();
        bus.DSP_A     = 16'h1234;
        bus.SMP_A     = 16'h5678;
        bus.HOST_A    = 16'h9ABC;
        bus.DSP_WE_N  = 1'b1;
        bus.SMP_WE_N  = 1'b1;
        bus.HOST_WE_N = 1'b1;
        bus.DSP_REQ   = 1'b1;
        bus.SMP_REQ   = 1'b1;
        bus.HOST_REQ  = 1'b1;
        step();
        n_compared++;
        if ({bus.DSP_ACK, bus.SMP_ACK, bus.HOST_ACK, bus.MEM_A} !== {3'b100, 16'h1234}) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_ack1: got %b%b%b a=%h expected 100 1234",
                     bus.DSP_ACK, bus.SMP_ACK, bus.HOST_ACK, bus.MEM_A);
        end
        bus.DSP_REQ = 1'b0;
        step();
        n_compared++;
        if ({bus.DSP_ACK, bus.SMP_ACK, bus.HOST_ACK, bus.MEM_A} !== {3'b010, 16'h5678}) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_ack2: got %b%b%b a=%h expected 010 5678",
                     bus.DSP_ACK, bus.SMP_ACK, bus.HOST_ACK, bus.MEM_A);
        end
        bus.SMP_REQ = 1'b0;
        step();
        n_compared++;
        if ({bus.DSP_ACK, bus.SMP_ACK, bus.HOST_ACK, bus.MEM_A} !== {3'b001, 16'h9ABC}) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_ack3: got %b%b%b a=%h expected 001 9abc",
                     bus.DSP_ACK, bus.SMP_ACK, bus.HOST_ACK, bus.MEM_A);
        end
        n_compared++;
        if ({bus.DSP_RVALID, bus.SMP_RVALID, bus.HOST_RVALID, bus.DSP_DI} !== {3'b100, 8'h34}) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_ret1: got rv=%b%b%b di=%h expected 100 34",
                     bus.DSP_RVALID, bus.SMP_RVALID, bus.HOST_RVALID, bus.DSP_DI);
        end
        bus.HOST_REQ = 1'b0;
        step();
        n_compared++;
        if ({bus.DSP_RVALID, bus.SMP_RVALID, bus.HOST_RVALID, bus.SMP_DI} !== {3'b010, 8'h78}) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_ret2: got rv=%b%b%b di=%h expected 010 78",
                     bus.DSP_RVALID, bus.SMP_RVALID, bus.HOST_RVALID, bus.SMP_DI);
        end
        step();
        n_compared++;
        if ({bus.DSP_RVALID, bus.SMP_RVALID, bus.HOST_RVALID, bus.HOST_DI, bus.DSP_DI} !== {3'b001, 8'hBC, 8'h34}) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_ret3: got rv=%b%b%b host_di=%h dsp_di=%h expected 001 bc 34",
                     bus.DSP_RVALID, bus.SMP_RVALID, bus.HOST_RVALID, bus.HOST_DI, bus.DSP_DI);
        end
        repeat (3) step();
    endtask

    task automatic test_reset_in_flight();
        bus.SMP_A    = 16'h0042;
        bus.SMP_WE_N = 1'b1;
        bus.SMP_REQ  = 1'b1;
        step();
        n_compared++;
        if ({bus.SMP_ACK, bus.MEM_A} !== {1'b1, 16'h0042}) begin
            n_mismatched++;
            $display("[TB] FAIL flight_ack: got ack=%b a=%h expected 1 0042", bus.SMP_ACK, bus.MEM_A);
        end
        bus.SMP_REQ = 1'b0;
        RST_N = 1'b0;
        step();
        n_compared++;
        if ({bus.DSP_ACK, bus.SMP_ACK, bus.HOST_ACK, bus.DSP_RVALID, bus.SMP_RVALID, bus.HOST_RVALID,
             bus.MEM_CE, bus.MEM_WE_N, bus.MEM_A, bus.MEM_DO, bus.DSP_DI, bus.SMP_DI, bus.HOST_DI} !==
            {6'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 24'h0}) begin
            n_mismatched++;
            $display("[TB] FAIL flight_reset: got ack=%b%b%b rv=%b%b%b ce=%b we_n=%b a=%h do=%h di=%h%h%h",
                     bus.DSP_ACK, bus.SMP_ACK, bus.HOST_ACK, bus.DSP_RVALID, bus.SMP_RVALID, bus.HOST_RVALID,
                     bus.MEM_CE, bus.MEM_WE_N, bus.MEM_A, bus.MEM_DO, bus.DSP_DI, bus.SMP_DI, bus.HOST_DI);
        end
        RST_N = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            n_compared++;
            if ({bus.DSP_RVALID, bus.SMP_RVALID, bus.HOST_RVALID, bus.SMP_DI} !== {3'b000, 8'h00}) begin
                n_mismatched++;
                $display("[TB] FAIL flight_no_return_%0d: got rv=%b%b%b di=%h expected 000 00", k,
                         bus.DSP_RVALID, bus.SMP_RVALID, bus.HOST_RVALID, bus.SMP_DI);
            end
        end
    endtask

    initial begin
        n_compared    = 0;
        n_mismatched  = 0;
        RST_N         = 1'b0;
        bus.DSP_REQ   = 1'b0;
        bus.DSP_A     = '0;
        bus.DSP_DO    = '0;
        bus.DSP_WE_N  = 1'b1;
        bus.SMP_REQ   = 1'b0;
        bus.SMP_A     = '0;
        bus.SMP_DO    = '0;
        bus.SMP_WE_N  = 1'b1;
        bus.HOST_REQ  = 1'b0;
        bus.HOST_A    = '0;
        bus.HOST_DO   = '0;
        bus.HOST_WE_N = 1'b1;
        bus.HOST_LOCK = 1'b0;
        #1;
        test_reset();
        test_single_read();
        test_alternate();
        test_starve();
        test_host_lock();
        test_back_to_back();
        test_reset_in_flight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
